// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction-memory and IF/ID bundle for fetch_ctrl
//
// Purpose: groups the imem request/response handshake and the IF/ID delivery
// signals of the fetch stage into one bundle.
//
// Signal names are the fetch_ctrl port names, so the _o/_i suffixes are seen
// from the fetch_ctrl side.
//   imem_req_o    : request valid
//   imem_addr_o   : request address (current fetch PC)
//   imem_gnt_i    : request accepted this cycle
//   imem_rvalid_i : response valid
//   imem_rdata_i  : response instruction word
//   if_valid_o    : if_pc_o / if_instr_o valid
//   if_pc_o       : PC of the delivered instruction
//   if_instr_o    : delivered instruction
//   if_misalign_o : delivered entry is a misaligned-fetch marker
//                   (present only with FETCH_MISALIGN_TRAP_EN)
//
// Modports:
//   master : fetch_ctrl side
//   slave  : memory / IF-ID side
interface fetch_ctrl_if #(
   parameter int PC_WIDTH    = 64,
   parameter int INSTR_WIDTH = 32
);
   logic                   imem_req_o;
   logic [PC_WIDTH-1:0]    imem_addr_o;
   logic                   imem_gnt_i;
   logic                   imem_rvalid_i;
   logic [INSTR_WIDTH-1:0] imem_rdata_i;
   logic                   if_valid_o;
   logic [PC_WIDTH-1:0]    if_pc_o;
   logic [INSTR_WIDTH-1:0] if_instr_o;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic                   if_misalign_o;

   modport master (
      output imem_req_o, imem_addr_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      output if_valid_o, if_pc_o, if_instr_o, if_misalign_o
   );

   modport slave (
      input  imem_req_o, imem_addr_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      input  if_valid_o, if_pc_o, if_instr_o, if_misalign_o
   );
`else
   modport master (
      output imem_req_o, imem_addr_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      output if_valid_o, if_pc_o, if_instr_o
   );

   modport slave (
      input  imem_req_o, imem_addr_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      input  if_valid_o, if_pc_o, if_instr_o
   );
`endif
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage PC driver with single-outstanding imem request
//
// Purpose: owns the fetch PC and issues one instruction-memory request at a time.
// It handles redirects (branch/jump/trap) and IF/ID back-pressure, and delivers
// {pc, instr} to IF/ID through an output register backed by a 1-entry skid.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   When it is defined, a redirect to a PC with bits [1:0] != 0 issues no fetch.
//   Instead one NOP entry is delivered with if_misalign_o=1, and fetch halts
//   until the next redirect.
//   When it is undefined, redirect_pc_i[1:0] is forced to 2'b00.
//
// Ports:
//   clk           : clock, all state updates on posedge
//   rst           : synchronous active-high reset
//   stall_i       : IF/ID cannot accept, hold if_* outputs
//   redirect_i    : load redirect_pc_i as new fetch PC, kill in-flight work
//   redirect_pc_i : redirect target
//   bus           : fetch_ctrl_if.master (imem handshake and IF/ID outputs)
module fetch_ctrl #(
   parameter int                     PC_WIDTH    = 64,
   parameter int                     INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_i,
   input  logic                redirect_i,
   input  logic [PC_WIDTH-1:0] redirect_pc_i,
   fetch_ctrl_if.master        bus
);

   typedef enum logic [1:0] {
      S_REQ,    // may issue a request
      S_WAIT,   // one request outstanding
      S_DROP,   // outstanding response will be discarded
      S_HALT    // halted after a misaligned redirect
   } state_t;

   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(32'h0000_0013);

   state_t                 state_q,     state_d;
   logic [PC_WIDTH-1:0]    fetch_pc_q,  fetch_pc_d;
   logic [PC_WIDTH-1:0]    req_pc_q,    req_pc_d;
   logic                   out_valid_q, out_valid_d;
   logic [PC_WIDTH-1:0]    out_pc_q,    out_pc_d;
   logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
   logic                   out_mis_q,   out_mis_d;
   logic                   skid_valid_q, skid_valid_d;
   logic [PC_WIDTH-1:0]    skid_pc_q,    skid_pc_d;
   logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
   logic                   halt_q,      halt_d;

   logic                   imem_req;
   logic                   handshake;
   logic                   resp;
   logic                   out_free;
   logic [PC_WIDTH-1:0]    rd_pc;
   logic                   rd_mis;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign rd_pc  = redirect_pc_i;
   assign rd_mis = |redirect_pc_i[1:0];
`else
   // Low bits are masked rather than sliced so that every input bit is consumed.
   assign rd_pc  = redirect_pc_i & ~PC_WIDTH'(3);
   assign rd_mis = 1'b0;
`endif

   // Gated by rst so that no request is visible during the reset cycle.
   // A full skid blocks issue: the response would have nowhere to go.
   assign imem_req  = !rst && (state_q == S_REQ) && !skid_valid_q;
   assign handshake = imem_req && bus.imem_gnt_i;
   // Only a response to a live request counts. Responses in DROP are discarded.
   assign resp      = (state_q == S_WAIT) && bus.imem_rvalid_i;
   // The output register can take a new entry if it is empty or is drained this cycle.
   assign out_free  = !out_valid_q || !stall_i;

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      req_pc_d     = req_pc_q;
      out_valid_d  = out_valid_q;
      out_pc_d     = out_pc_q;
      out_instr_d  = out_instr_q;
      out_mis_d    = out_mis_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      halt_d       = halt_q;

      if (redirect_i) begin
         // Redirect overrides stall: everything already fetched is wrong-path.
         fetch_pc_d   = rd_pc;
         out_valid_d  = 1'b0;
         out_mis_d    = 1'b0;
         skid_valid_d = 1'b0;
         halt_d       = 1'b0;
         case (state_q)
            S_REQ:          state_d = handshake ? S_DROP : S_REQ;
            // A response arriving together with the redirect is the one to
            // discard, so nothing is left outstanding.
            S_WAIT, S_DROP: state_d = bus.imem_rvalid_i ? S_REQ : S_DROP;
            default:        state_d = S_REQ;
         endcase
         if (rd_mis) begin
            out_valid_d = 1'b1;
            out_pc_d    = redirect_pc_i;
            out_instr_d = NOP_INSTR;
            out_mis_d   = 1'b1;
            // If a response still has to be dropped, halt once it arrives.
            halt_d      = 1'b1;
            if (state_d == S_REQ) begin
               state_d = S_HALT;
            end
         end
      end else begin
         case (state_q)
            S_REQ: begin
               if (handshake) begin
                  state_d  = S_WAIT;
                  req_pc_d = fetch_pc_q;
               end
            end
            S_WAIT: begin
               if (bus.imem_rvalid_i) begin
                  state_d    = S_REQ;
                  fetch_pc_d = req_pc_q + PC_WIDTH'(4);
               end
            end
            S_DROP: begin
               if (bus.imem_rvalid_i) begin
                  state_d = halt_q ? S_HALT : S_REQ;
               end
            end
            default: begin
               state_d = S_HALT;
            end
         endcase

         // Delivery order is skid (older), then this cycle's response (newer).
         if (out_free) begin
            if (skid_valid_q) begin
               out_valid_d = 1'b1;
               out_pc_d    = skid_pc_q;
               out_instr_d = skid_instr_q;
               out_mis_d   = 1'b0;
               if (resp) begin
                  skid_pc_d    = req_pc_q;
                  skid_instr_d = bus.imem_rdata_i;
               end else begin
                  skid_valid_d = 1'b0;
               end
            end else if (resp) begin
               out_valid_d = 1'b1;
               out_pc_d    = req_pc_q;
               out_instr_d = bus.imem_rdata_i;
               out_mis_d   = 1'b0;
            end else begin
               out_valid_d = 1'b0;
               out_mis_d   = 1'b0;
            end
         end else if (resp) begin
            // The output is held by the stall. Requests stop while the skid is
            // full, so the skid is always empty here.
            skid_valid_d = 1'b1;
            skid_pc_d    = req_pc_q;
            skid_instr_d = bus.imem_rdata_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_REQ;
         fetch_pc_q   <= RESET_PC;
         req_pc_q     <= '0;
         out_valid_q  <= 1'b0;
         out_pc_q     <= '0;
         out_instr_q  <= '0;
         out_mis_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
         halt_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         req_pc_q     <= req_pc_d;
         out_valid_q  <= out_valid_d;
         out_pc_q     <= out_pc_d;
         out_instr_q  <= out_instr_d;
         out_mis_q    <= out_mis_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         halt_q       <= halt_d;
      end
   end

   assign bus.imem_req_o  = imem_req;
   assign bus.imem_addr_o = fetch_pc_q;
   assign bus.if_valid_o  = out_valid_q;
   assign bus.if_pc_o     = out_pc_q;
   assign bus.if_instr_o  = out_instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign bus.if_misalign_o = out_mis_q;
`endif

endmodule
